// File: rtl/memory_stage.sv
// memory_stage: EX/MEM register, req/ack data-memory access with timeout, branch resolve, MEM/WB register
module memory_stage #(
    parameter int N       = 64,
    parameter int TIMEOUT = 16
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_valid_E,
    input  logic         i_regWrite_E,
    input  logic         i_memtoReg_E,
    input  logic         i_memRead_E,
    input  logic         i_memWrite_E,
    input  logic         i_branch_E,
    input  logic         i_zero_E,
    input  logic [4:0]   i_rd_E,
    input  logic [N-1:0] i_PCBranch_E,
    input  logic [N-1:0] i_aluResult_E,
    input  logic [N-1:0] i_writeData_E,
    output logic         o_stall,
    output logic         o_PCSrc_M,
    output logic [N-1:0] o_PCBranch_M,
    output logic         o_dm_req,
    output logic         o_dm_we,
    output logic [N-1:0] o_dm_addr,
    output logic [N-1:0] o_dm_wdata,
    input  logic [N-1:0] i_dm_rdata,
    input  logic         i_dm_ack,
    output logic         o_valid_W,
    output logic         o_regWrite_W,
    output logic         o_memtoReg_W,
    output logic [4:0]   o_rd_W,
    output logic [N-1:0] o_aluResult_W,
    output logic [N-1:0] o_readData_W,
    output logic         o_bus_error
);
    localparam int CW = $clog2(TIMEOUT + 1);
    typedef enum logic {IDLE, ACCESS} state_t;
    state_t r_state, w_next;
    logic [CW-1:0] r_cnt;
    logic r_valid, r_regWrite, r_memtoReg, r_memRead, r_memWrite, r_branch, r_zero;
    logic [4:0] r_rd;
    logic [N-1:0] r_PCBranch, r_aluResult, r_writeData;
    logic r_valid_W, r_regWrite_W, r_memtoReg_W, r_bus_error;
    logic [4:0] r_rd_W;
    logic [N-1:0] r_aluResult_W, r_readData_W;
    logic w_access, w_timeout, w_stall, w_mem_e, w_mem_m, w_valid_w, w_load;
    assign w_access  = r_state == ACCESS;
    assign w_timeout = w_access & (r_cnt == CW'(TIMEOUT - 1)) & ~i_dm_ack;
    assign w_stall   = w_access & ~i_dm_ack & ~w_timeout;
    assign w_mem_e   = i_valid_E & (i_memRead_E | i_memWrite_E);
    assign w_mem_m   = r_valid & (r_memRead | r_memWrite);
    assign w_valid_w = r_valid & (~w_mem_m | (w_access & i_dm_ack) | w_timeout);
    assign w_load    = w_access & i_dm_ack & r_memRead & ~r_memWrite;
    always_comb begin
        w_next = (w_stall | w_mem_e) ? ACCESS : IDLE;
    end
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state       <= IDLE;
            r_cnt         <= '0;
            r_valid       <= 1'b0;
            r_regWrite    <= 1'b0;
            r_memtoReg    <= 1'b0;
            r_memRead     <= 1'b0;
            r_memWrite    <= 1'b0;
            r_branch      <= 1'b0;
            r_zero        <= 1'b0;
            r_rd          <= '0;
            r_PCBranch    <= '0;
            r_aluResult   <= '0;
            r_writeData   <= '0;
            r_valid_W     <= 1'b0;
            r_regWrite_W  <= 1'b0;
            r_memtoReg_W  <= 1'b0;
            r_rd_W        <= '0;
            r_aluResult_W <= '0;
            r_readData_W  <= '0;
            r_bus_error   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_stall ? r_cnt + CW'(1) : '0;
            if (!w_stall) begin
                r_valid     <= i_valid_E;
                r_regWrite  <= i_regWrite_E;
                r_memtoReg  <= i_memtoReg_E;
                r_memRead   <= i_memRead_E;
                r_memWrite  <= i_memWrite_E;
                r_branch    <= i_branch_E;
                r_zero      <= i_zero_E;
                r_rd        <= i_rd_E;
                r_PCBranch  <= i_PCBranch_E;
                r_aluResult <= i_aluResult_E;
                r_writeData <= i_writeData_E;
            end
            r_valid_W     <= w_valid_w;
            r_regWrite_W  <= w_valid_w & r_regWrite & ~w_timeout;
            r_memtoReg_W  <= r_memtoReg;
            r_rd_W        <= r_rd;
            r_aluResult_W <= r_aluResult;
            r_readData_W  <= w_load ? i_dm_rdata : '0;
            r_bus_error   <= r_bus_error | w_timeout;
        end
    end
    assign o_stall       = w_stall;
    assign o_PCSrc_M     = r_valid & r_branch & r_zero;
    assign o_PCBranch_M  = r_PCBranch;
    assign o_dm_req      = w_access;
    assign o_dm_we       = r_memWrite;
    assign o_dm_addr     = r_aluResult;
    assign o_dm_wdata    = r_writeData;
    assign o_valid_W     = r_valid_W;
    assign o_regWrite_W  = r_regWrite_W;
    assign o_memtoReg_W  = r_memtoReg_W;
    assign o_rd_W        = r_rd_W;
    assign o_aluResult_W = r_aluResult_W;
    assign o_readData_W  = r_readData_W;
    assign o_bus_error   = r_bus_error;
endmodule

// File: tb/tb_memory_stage.sv
// tb_memory_stage: directed checks of memory_stage with TIMEOUT=4
module tb_memory_stage;
    logic        clk = 1'b0;
    logic        reset;
    logic        valid_E, regWrite_E, memtoReg_E, memRead_E, memWrite_E, branch_E, zero_E;
    logic [4:0]  rd_E;
    logic [63:0] PCBranch_E, aluResult_E, writeData_E;
    logic        stall, PCSrc_M, dm_req, dm_we, dm_ack;
    logic [63:0] PCBranch_M, dm_addr, dm_wdata, dm_rdata;
    logic        valid_W, regWrite_W, memtoReg_W, bus_error;
    logic [4:0]  rd_W;
    logic [63:0] aluResult_W, readData_W;
    int vectors = 0;
    int miscompares = 0;

    memory_stage #(.N(64), .TIMEOUT(4)) dut (
        .i_clk(clk), .i_reset(reset),
        .i_valid_E(valid_E), .i_regWrite_E(regWrite_E), .i_memtoReg_E(memtoReg_E),
        .i_memRead_E(memRead_E), .i_memWrite_E(memWrite_E), .i_branch_E(branch_E),
        .i_zero_E(zero_E), .i_rd_E(rd_E), .i_PCBranch_E(PCBranch_E),
        .i_aluResult_E(aluResult_E), .i_writeData_E(writeData_E),
        .o_stall(stall), .o_PCSrc_M(PCSrc_M), .o_PCBranch_M(PCBranch_M),
        .o_dm_req(dm_req), .o_dm_we(dm_we), .o_dm_addr(dm_addr), .o_dm_wdata(dm_wdata),
        .i_dm_rdata(dm_rdata), .i_dm_ack(dm_ack),
        .o_valid_W(valid_W), .o_regWrite_W(regWrite_W), .o_memtoReg_W(memtoReg_W),
        .o_rd_W(rd_W), .o_aluResult_W(aluResult_W), .o_readData_W(readData_W),
        .o_bus_error(bus_error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_e();
        valid_E = 0; regWrite_E = 0; memtoReg_E = 0; memRead_E = 0; memWrite_E = 0;
        branch_E = 0; zero_E = 0; rd_E = 0; PCBranch_E = 0; aluResult_E = 0; writeData_E = 0;
    endtask

    task automatic load_e(input logic [4:0] rd, input logic [63:0] addr);
        clr_e();
        valid_E = 1; regWrite_E = 1; memtoReg_E = 1; memRead_E = 1; rd_E = rd; aluResult_E = addr;
    endtask

    initial begin
        clr_e();
        dm_ack = 0; dm_rdata = 0;
        // reset with a valid mem op presented
        reset = 0;
        valid_E = 1; regWrite_E = 1; memRead_E = 1; rd_E = 5; aluResult_E = 64'h55;
        tick();
        chk("rst_valid_W", valid_W, 0);
        chk("rst_regWrite_W", regWrite_W, 0);
        chk("rst_dm_req", dm_req, 0);
        chk("rst_stall", stall, 0);
        chk("rst_PCSrc_M", PCSrc_M, 0);
        chk("rst_bus_error", bus_error, 0);
        chk("rst_rd_W", rd_W, 0);
        chk("rst_aluResult_W", aluResult_W, 0);
        tick();
        chk("rst_hold_dm_req", dm_req, 0);
        // ALU stream
        reset = 1;
        clr_e(); valid_E = 1; regWrite_E = 1; rd_E = 1; aluResult_E = 64'h11;
        tick();
        rd_E = 2; aluResult_E = 64'h22;
        tick();
        chk("alu1_rd_W", rd_W, 1);
        chk("alu1_valid_W", valid_W, 1);
        chk("alu1_regWrite_W", regWrite_W, 1);
        chk("alu1_aluResult_W", aluResult_W, 64'h11);
        chk("alu1_stall", stall, 0);
        rd_E = 3; aluResult_E = 64'h33;
        tick();
        chk("alu2_rd_W", rd_W, 2);
        chk("alu2_valid_W", valid_W, 1);
        clr_e();
        tick();
        chk("alu3_rd_W", rd_W, 3);
        chk("alu3_valid_W", valid_W, 1);
        chk("alu3_regWrite_W", regWrite_W, 1);
        tick();
        chk("alu_after_valid_W", valid_W, 0);
        // load with 3 wait states
        load_e(4, 64'h100);
        tick();
        clr_e(); #1;
        chk("ld_dm_req", dm_req, 1);
        chk("ld_dm_addr", dm_addr, 64'h100);
        chk("ld_dm_we", dm_we, 0);
        chk("ld_stall0", stall, 1);
        tick();
        chk("ld_bubble1", valid_W, 0);
        chk("ld_stall1", stall, 1);
        chk("ld_addr_hold", dm_addr, 64'h100);
        tick();
        chk("ld_bubble2", valid_W, 0);
        chk("ld_stall2", stall, 1);
        tick();
        chk("ld_bubble3", valid_W, 0);
        dm_ack = 1; dm_rdata = 64'hDEAD; #1;
        chk("ld_ack_stall", stall, 0);
        chk("ld_ack_dm_req", dm_req, 1);
        tick();
        dm_ack = 0; dm_rdata = 0; #1;
        chk("ld_valid_W", valid_W, 1);
        chk("ld_regWrite_W", regWrite_W, 1);
        chk("ld_readData_W", readData_W, 64'hDEAD);
        chk("ld_memtoReg_W", memtoReg_W, 1);
        chk("ld_rd_W", rd_W, 4);
        chk("ld_aluResult_W", aluResult_W, 64'h100);
        chk("ld_done_dm_req", dm_req, 0);
        chk("ld_bus_error", bus_error, 0);
        // back-to-back store then load, zero wait
        clr_e(); valid_E = 1; memWrite_E = 1; aluResult_E = 64'h200; writeData_E = 64'hAB;
        tick();
        load_e(7, 64'h208);
        dm_ack = 1; dm_rdata = 64'h1234; #1;
        chk("st_dm_req", dm_req, 1);
        chk("st_dm_we", dm_we, 1);
        chk("st_dm_addr", dm_addr, 64'h200);
        chk("st_dm_wdata", dm_wdata, 64'hAB);
        chk("st_stall", stall, 0);
        tick();
        clr_e(); dm_rdata = 64'h5678; #1;
        chk("b2b_dm_req", dm_req, 1);
        chk("b2b_dm_we", dm_we, 0);
        chk("b2b_dm_addr", dm_addr, 64'h208);
        chk("b2b_stall", stall, 0);
        chk("st_valid_W", valid_W, 1);
        chk("st_regWrite_W", regWrite_W, 0);
        chk("st_readData_W", readData_W, 0);
        tick();
        dm_ack = 0; dm_rdata = 0; #1;
        chk("b2b_done_dm_req", dm_req, 0);
        chk("b2b_valid_W", valid_W, 1);
        chk("b2b_rd_W", rd_W, 7);
        chk("b2b_readData_W", readData_W, 64'h5678);
        chk("b2b_regWrite_W", regWrite_W, 1);
        // branches
        clr_e(); valid_E = 1; branch_E = 1; zero_E = 1; PCBranch_E = 64'h40;
        tick();
        clr_e(); valid_E = 1; branch_E = 1; zero_E = 0; PCBranch_E = 64'h80; #1;
        chk("br_taken_PCSrc", PCSrc_M, 1);
        chk("br_taken_target", PCBranch_M, 64'h40);
        tick();
        clr_e(); #1;
        chk("br_not_taken_PCSrc", PCSrc_M, 0);
        chk("br_not_taken_target", PCBranch_M, 64'h80);
        tick();
        chk("br_idle_PCSrc", PCSrc_M, 0);
        // timeout, no ack
        load_e(9, 64'h300);
        tick();
        clr_e(); #1;
        chk("to_stall0", stall, 1);
        tick();
        chk("to_stall1", stall, 1);
        tick();
        chk("to_stall2", stall, 1);
        tick();
        chk("to_last_stall", stall, 0);
        chk("to_last_dm_req", dm_req, 1);
        chk("to_last_bus_error", bus_error, 0);
        tick();
        chk("to_valid_W", valid_W, 1);
        chk("to_regWrite_W", regWrite_W, 0);
        chk("to_readData_W", readData_W, 0);
        chk("to_bus_error", bus_error, 1);
        chk("to_rd_W", rd_W, 9);
        chk("to_dm_req", dm_req, 0);
        // ack while idle is ignored; error stays sticky
        dm_ack = 1; dm_rdata = 64'hFF; #1;
        chk("idle_ack_stall", stall, 0);
        tick();
        dm_ack = 0; dm_rdata = 0; #1;
        chk("idle_ack_valid_W", valid_W, 0);
        chk("idle_ack_readData_W", readData_W, 0);
        chk("idle_ack_dm_req", dm_req, 0);
        chk("sticky_bus_error", bus_error, 1);
        // reset during ACCESS
        load_e(10, 64'h400);
        tick();
        clr_e(); #1;
        chk("ra_dm_req", dm_req, 1);
        reset = 0;
        tick();
        chk("ra_rst_dm_req", dm_req, 0);
        chk("ra_rst_stall", stall, 0);
        chk("ra_rst_valid_W", valid_W, 0);
        chk("ra_rst_bus_error", bus_error, 0);
        reset = 1;
        tick();
        chk("ra_after_valid_W", valid_W, 0);
        chk("ra_after_dm_req", dm_req, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/memory_stage.md
# memory_stage

Pipeline stage directly downstream of the execute stage in the 64-bit LEGv8 pipeline. It holds the EX/MEM pipeline register, runs data-memory loads and stores over a req/ack bus with a wait-state timeout, and resolves taken branches (`PCSrc_M`). It also produces the MEM/WB register contents and stalls upstream stages while a memory access is outstanding.

## Interface
- `N`, 64: datapath width.
- `TIMEOUT`, 16: maximum number of cycles spent in ACCESS before a forced completion. Must be ≥ 1.

- `clk`  in  1  clock, rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `valid_E, regWrite_E, memtoReg_E, memRead_E, memWrite_E, branch_E, zero_E`  in  1 each  EX outputs and control.
- `rd_E`  in  5  destination register.
- `PCBranch_E, aluResult_E, writeData_E`  in  N  EX results.
- `stall`  out  1  freezes EX and all earlier stages.
- `PCSrc_M`  out  1  branch taken.
- `PCBranch_M`  out  N  branch target.
- `dm_req, dm_we`  out  1  memory request / write enable.
- `dm_addr, dm_wdata`  out  N  memory address / store data.
- `dm_rdata`  in  N  load data, valid when `dm_ack`=1.
- `dm_ack`  in  1  completes the current request.
- `valid_W, regWrite_W, memtoReg_W`  out  1  MEM/WB control.
- `rd_W`  out  5  MEM/WB destination register.
- `aluResult_W, readData_W`  out  N  MEM/WB data.
- `bus_error`  out  1  sticky timeout flag.

## Operation
- M register (`M_*`) captures all `*_E` inputs at each edge where `stall`=0. It holds while `stall`=1.
- "mem op": `M_valid & (M_memRead | M_memWrite)`. A simultaneous memRead and memWrite is treated as a store.
- FSM states:
  - IDLE → ACCESS: at an edge where `stall`=0 and the incoming E op is a mem op.
  - ACCESS → IDLE: on `dm_ack`=1 or timeout, when the next E op is not a mem op.
  - ACCESS → ACCESS (re-entered): when the next E op is a mem op; counter is cleared. Back-to-back accesses are allowed.
- Timeout: `timeout` = ACCESS & (cnt == TIMEOUT-1) & !`dm_ack`. Counter `cnt` clears on entering ACCESS and increments each ACCESS cycle.
- Outputs:
  - `stall` = ACCESS & !`dm_ack` & !`timeout`. This path is combinational through `dm_ack`.
  - `dm_req` = ACCESS.
  - `dm_we` = `M_memWrite`, `dm_addr` = `M_aluResult`, `dm_wdata` = `M_writeData`. All held stable while `dm_req`=1.
  - `PCSrc_M` = `M_valid & M_branch & M_zero`; `PCBranch_M` = `M_PCBranch`. Both are combinational from the M register.
- W register updates at every edge:
  - `valid_W` = `M_valid` & (!mem op | `dm_ack` | `timeout`). A stalled cycle produces a bubble: `valid_W`=0 and `regWrite_W`=0.
  - `regWrite_W` = `valid_W & M_regWrite & !timeout`.
  - `readData_W` = `dm_rdata` on ack; 0 on timeout; 0 for non-loads.
  - `aluResult_W`, `rd_W`, `memtoReg_W` are copied from M.
- `bus_error` is set at a timeout edge and cleared only by reset.

## Timing
- Reset (`reset`=0 at an edge): the following all become 0 on the next cycle:
  - FSM → IDLE, `cnt`.
  - All `M_*` and `*_W` registers.
  - `dm_req`, `stall`, `PCSrc_M`, `bus_error`.
- Reset during ACCESS abandons the request: `dm_req` drops the cycle after the reset edge, and no W write occurs.
- Non-mem op: E→M at edge k, M→W at edge k+1. Latency is 2 edges with no stall.
- Mem op with ack in the first ACCESS cycle: `stall`=0 in that cycle. Latency is the same as a non-mem op.
- Mem op with w wait cycles: `stall`=1 for w cycles, and W receives w bubbles before the valid result.
- Timeout: forced completion on the edge ending ACCESS cycle TIMEOUT. An ack arriving in that same cycle takes priority, and no error is raised.
- A `dm_ack` seen in IDLE is ignored.

## Test plan
- Reset: drive `reset`=0 with `valid_E`=1 → after the edge, all outputs are 0 and FSM is IDLE. Repeat with the FSM in ACCESS → `dm_req` falls next cycle and `valid_W` stays 0.
- ALU op stream: three ADDs with `rd_E`=1,2,3 and no stalls → `rd_W`=1,2,3 on consecutive cycles, each with `valid_W`=1 and `regWrite_W`=1.
- Load with 3 wait states: `aluResult_E`=0x100, ack on the 4th ACCESS cycle with `dm_rdata`=0xDEAD → `dm_addr`=0x100, `stall` high for 3 cycles, 3 bubbles, then `readData_W`=0xDEAD and `memtoReg_W`=1.
- Back-to-back store then load, zero-wait ack → `dm_req` stays 1 for 2 cycles, `dm_we`=1 then 0, `stall` never asserted.
- Branch: `branch_E`=1, `zero_E`=1, `PCBranch_E`=0x40 → `PCSrc_M`=1 and `PCBranch_M`=0x40 for one cycle. Same with `zero_E`=0 → `PCSrc_M`=0.
- Timeout, `TIMEOUT`=4, no ack → `stall` high for 3 cycles; at the 4th edge `valid_W`=1, `regWrite_W`=0, `readData_W`=0, `bus_error`=1, which stays set until reset.
